// File: rtl/ahb_ext_sub.sv
// AHB-Lite external-memory subordinate: word-organised RAM with programmable
// wait states and two-cycle ERROR responses for oversize/misaligned transfers.
module ahb_ext_sub #(
   parameter int unsigned AHBW       = 64,
   parameter int unsigned PA_BITS    = 34,
   parameter int unsigned DEPTH      = 4096,
   parameter int unsigned WAITSTATES = 2
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   input  logic                HSEL,
   input  logic [PA_BITS-1:0]  HADDR,
   input  logic [1:0]          HTRANS,
   input  logic                HWRITE,
   input  logic [2:0]          HSIZE,
   input  logic [AHBW-1:0]     HWDATA,
   input  logic [AHBW/8-1:0]   HWSTRB,
   input  logic                HREADY,
   output logic [AHBW-1:0]     HRDATA,
   output logic                HREADYOUT,
   output logic                HRESP
);

   localparam int unsigned BB = $clog2(AHBW/8);
   localparam int unsigned IW = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = (WAITSTATES > 0) ? 4'(WAITSTATES - 1) : '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ERR1 = 2'd2,
      ERR2 = 2'd3
   } state_t;

   state_t          state, state_n;
   logic [3:0]      cnt, cnt_n;
   logic            act, act_n;
   logic [IW-1:0]   a_idx, idx_n;
   logic            a_write, wr_n;
   logic [BB-1:0]   mask;
   logic            accept, legal, complete;
   logic [AHBW-1:0] mem [DEPTH];
   logic            unused_ok;

   assign unused_ok = ^{HADDR[PA_BITS-1:IW+BB], HTRANS[0]};

   assign accept = HSEL & HREADY & HTRANS[1];

   always_comb begin
      for (int unsigned i = 0; i < BB; i++)
         mask[i] = (i < 32'(HSIZE));
   end

   assign legal = (32'(HSIZE) <= BB) && ((HADDR[BB-1:0] & mask) == '0);

   // act marks a legal transfer owning the current data phase; in IDLE it is the completing cycle
   assign complete = (state == IDLE) && act;

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state   <= IDLE;
         cnt     <= '0;
         act     <= 1'b0;
         a_idx   <= '0;
         a_write <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         act     <= act_n;
         a_idx   <= idx_n;
         a_write <= wr_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      act_n     = act;
      idx_n     = a_idx;
      wr_n      = a_write;
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      case (state)
         IDLE: act_n = 1'b0;
         WAIT: begin
            HREADYOUT = 1'b0;
            if (cnt == '0) state_n = IDLE;
            else           cnt_n   = cnt - 4'd1;
         end
         ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
            state_n   = ERR2;
         end
         ERR2: begin
            HRESP   = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (HREADYOUT && accept) begin
         if (legal) begin
            act_n = 1'b1;
            idx_n = HADDR[IW+BB-1:BB];
            wr_n  = HWRITE;
            if (WAITSTATES > 0) begin
               state_n = WAIT;
               cnt_n   = CNT_INIT;
            end else begin
               state_n = IDLE;
            end
         end else begin
            act_n   = 1'b0;
            state_n = ERR1;
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESETn && complete && a_write) begin
         for (int unsigned i = 0; i < AHBW/8; i++)
            if (HWSTRB[i]) mem[a_idx][8*i +: 8] <= HWDATA[8*i +: 8];
      end
   end

   always_comb begin
      HRDATA = '0;
      if (complete && !a_write) HRDATA = mem[a_idx];
   end

endmodule

// File: tb/tb_ahb_ext_sub.sv
// Directed bench: a WAITSTATES=2 instance for single transfers, errors and
// reset, and a WAITSTATES=0 instance for the back-to-back burst.
module tb_ahb_ext_sub;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [33:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [63:0] hwdata;
   logic [7:0]  hwstrb;
   logic        hsel_a, hsel_b;
   logic [63:0] rd_a, rd_b;
   logic        ro_a, ro_b, rs_a, rs_b;

   int vectors    = 0;
   int miscompares = 0;

   always #5 HCLK = ~HCLK;

   ahb_ext_sub #(.AHBW(64), .PA_BITS(34), .DEPTH(4096), .WAITSTATES(2)) u_a (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_a), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HWSTRB(hwstrb), .HREADY(ro_a),
      .HRDATA(rd_a), .HREADYOUT(ro_a), .HRESP(rs_a));

   ahb_ext_sub #(.AHBW(64), .PA_BITS(34), .DEPTH(4096), .WAITSTATES(0)) u_b (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_b), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HWSTRB(hwstrb), .HREADY(ro_b),
      .HRDATA(rd_b), .HREADYOUT(ro_b), .HRESP(rs_b));

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One transfer on the WAITSTATES=2 instance: address phase, two wait cycles, completion.
   task automatic xfer_a(input logic wr, input logic [33:0] a, input logic [63:0] wd,
                         input logic [7:0] st, input logic [63:0] exp, input string tag);
      hsel_a = 1'b1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = 3'd3;
      tick();
      htrans = 2'b00; hwdata = wd; hwstrb = st;
      chk({tag, " ready w1"}, ro_a, 1'b0);
      tick();
      chk({tag, " ready w2"}, ro_a, 1'b0);
      tick();
      chk({tag, " ready done"}, ro_a, 1'b1);
      chk({tag, " resp"}, rs_a, 1'b0);
      if (!wr) chk({tag, " rdata"}, rd_a, exp);
      tick();
      hsel_a = 1'b0;
   endtask

   // Illegal transfer on the WAITSTATES=2 instance: two-cycle ERROR, then idle.
   task automatic err_a(input logic [33:0] a, input logic [2:0] sz, input string tag);
      hsel_a = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = a; hsize = sz;
      tick();
      htrans = 2'b00; hwdata = 64'hDEAD_BEEF_DEAD_BEEF; hwstrb = 8'hFF;
      chk({tag, " err1 ready"}, ro_a, 1'b0);
      chk({tag, " err1 resp"}, rs_a, 1'b1);
      chk({tag, " err1 rdata"}, rd_a, 64'h0);
      tick();
      chk({tag, " err2 ready"}, ro_a, 1'b1);
      chk({tag, " err2 resp"}, rs_a, 1'b1);
      chk({tag, " err2 rdata"}, rd_a, 64'h0);
      tick();
      chk({tag, " after resp"}, rs_a, 1'b0);
      hsel_a = 1'b0;
   endtask

   logic [33:0] b_addr [8] = '{34'h0, 34'h8, 34'h10, 34'h18, 34'h18, 34'h0, 34'h8, 34'h10};
   logic        b_wr   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   logic [63:0] b_dat  [8] = '{64'h0101_0202_0303_0404, 64'h1111_2222_3333_4444,
                               64'hA5A5_5A5A_F00F_0FF0, 64'h0123_4567_89AB_CDEF,
                               64'h0123_4567_89AB_CDEF, 64'h0101_0202_0303_0404,
                               64'h1111_2222_3333_4444, 64'hA5A5_5A5A_F00F_0FF0};

   initial begin
      HRESETn = 1'b0;
      hsel_a = 1'b1; hsel_b = 1'b1; htrans = 2'b10; hwrite = 1'b1;
      haddr = 34'h10; hsize = 3'd3; hwdata = 64'hFFFF_FFFF_FFFF_FFFF; hwstrb = 8'hFF;
      tick();
      tick();
      chk("reset ready a", ro_a, 1'b1);
      chk("reset resp a", rs_a, 1'b0);
      chk("reset rdata a", rd_a, 64'h0);
      chk("reset ready b", ro_b, 1'b1);
      chk("reset rdata b", rd_b, 64'h0);
      HRESETn = 1'b1; hsel_a = 1'b0; hsel_b = 1'b0; htrans = 2'b00;
      tick();
      chk("post reset ready a", ro_a, 1'b1);
      chk("post reset resp a", rs_a, 1'b0);

      xfer_a(1'b1, 34'h0_8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, "ws2 wr");
      xfer_a(1'b0, 34'h0_8000_0010, 64'h0, 8'h00, 64'h1122_3344_5566_7788, "ws2 rd");
      xfer_a(1'b1, 34'h0_8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 64'h0, "strb wr");
      xfer_a(1'b0, 34'h0_8000_0010, 64'h0, 8'h00, 64'h1122_3344_AAAA_AAAA, "strb rd");

      xfer_a(1'b1, 34'h0, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, "w0 wr");
      err_a(34'h4, 3'd3, "misalign");
      err_a(34'h0, 3'd4, "oversize");
      xfer_a(1'b0, 34'h0, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, "w0 intact");

      hsel_a = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 34'h0_8000_0010; hsize = 3'd3;
      tick();
      htrans = 2'b00; hwdata = 64'hCAFE_CAFE_CAFE_CAFE; hwstrb = 8'hFF;
      chk("rst wait1 ready", ro_a, 1'b0);
      tick();
      chk("rst wait2 ready", ro_a, 1'b0);
      HRESETn = 1'b0;
      tick();
      HRESETn = 1'b1; hsel_a = 1'b0;
      chk("rst mid ready", ro_a, 1'b1);
      chk("rst mid resp", rs_a, 1'b0);
      tick();
      xfer_a(1'b0, 34'h10, 64'h0, 8'h00, 64'h1122_3344_AAAA_AAAA, "rst old data");

      // Zero-wait burst: address of transfer c overlaps data of transfer c-1.
      for (int c = 0; c < 9; c++) begin
         if (c < 8) begin
            hsel_b = 1'b1; haddr = b_addr[c]; hwrite = b_wr[c]; hsize = 3'd3;
            htrans = (c == 0 || c == 4) ? 2'b10 : 2'b11;
         end else begin
            htrans = 2'b00; hsel_b = 1'b0;
         end
         if (c > 0 && b_wr[c-1]) begin
            hwdata = b_dat[c-1]; hwstrb = 8'hFF;
         end
         chk($sformatf("burst ready c%0d", c), ro_b, 1'b1);
         chk($sformatf("burst resp c%0d", c), rs_b, 1'b0);
         if (c > 0 && !b_wr[c-1]) chk($sformatf("burst rdata c%0d", c), rd_b, b_dat[c-1]);
         tick();
      end
      chk("burst idle ready", ro_b, 1'b1);
      chk("burst idle rdata", rd_b, 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
